// File: rtl/key_conditioner.sv
// Pushbutton conditioner: per-key synchronizer, debounce FSM, press/release
// pulses and hold-to-repeat pulse generation.
module key_conditioner #(
  parameter int unsigned N_KEYS      = 4,
  parameter int unsigned DB_CYCLES   = 1000000,
  parameter int unsigned HOLD_CYCLES = 25000000,
  parameter int unsigned RPT_CYCLES  = 5000000
) (
  input  logic              CLOCK_50,
  input  logic              Reset,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] Pressed,
  output logic [N_KEYS-1:0] KeyPress,
  output logic [N_KEYS-1:0] KeyRelease,
  output logic [N_KEYS-1:0] KeyRepeat
);

  localparam int unsigned CW = 25;
  localparam logic [CW-1:0] DB_LAST  = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_TGT = CW'(HOLD_CYCLES);
  // Reload value puts the next repeat exactly RPT_CYCLES after the previous one;
  // a repeat period longer than the hold time is clamped to the fastest legal reload.
  localparam logic [CW-1:0] RELOAD   =
    CW'((RPT_CYCLES <= HOLD_CYCLES) ? (HOLD_CYCLES - RPT_CYCLES + 1) : 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    DOWN       = 2'd2,
    DB_RELEASE = 2'd3
  } state_t;

  for (genvar i = 0; i < int'(N_KEYS); i++) begin : g_key
    logic [1:0]    sync;
    logic          s;
    state_t        state, state_n;
    logic [CW-1:0] dcnt, dcnt_n, hcnt, hcnt_n, hadv;
    logic          pressed_q, press_q, release_q, repeat_q;
    logic          pressed_n, press_n, release_n, repeat_n;

    assign s = ~sync[1];

    // State, counters, synchronizer and registered outputs
    always_ff @(posedge CLOCK_50 or posedge Reset) begin
      if (Reset) begin
        sync      <= 2'b11;
        state     <= IDLE;
        dcnt      <= '0;
        hcnt      <= '0;
        pressed_q <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        sync      <= {sync[0], KEY[i]};
        state     <= state_n;
        dcnt      <= dcnt_n;
        hcnt      <= hcnt_n;
        pressed_q <= pressed_n;
        press_q   <= press_n;
        release_q <= release_n;
        repeat_q  <= repeat_n;
      end
    end

    // Next-state, counter update and output decode
    always_comb begin
      state_n = state;
      dcnt_n  = dcnt;
      hcnt_n  = hcnt;
      hadv    = (hcnt == HOLD_TGT) ? RELOAD :
                (hcnt == CNT_MAX)  ? hcnt : hcnt + CW'(1);

      unique case (state)
        IDLE: begin
          if (s) begin
            state_n = DB_PRESS;
            dcnt_n  = '0;
          end
        end
        DB_PRESS: begin
          if (!s) begin
            state_n = IDLE;
          end else if (dcnt == DB_LAST) begin
            state_n = DOWN;
            hcnt_n  = '0;
          end else begin
            dcnt_n = dcnt + CW'(1);
          end
        end
        DOWN: begin
          hcnt_n = hadv;
          if (!s) begin
            state_n = DB_RELEASE;
            dcnt_n  = '0;
          end
        end
        DB_RELEASE: begin
          hcnt_n = hadv;
          if (s) begin
            state_n = DOWN;
          end else if (dcnt == DB_LAST) begin
            state_n = IDLE;
            hcnt_n  = '0;
          end else begin
            dcnt_n = dcnt + CW'(1);
          end
        end
        default: state_n = IDLE;
      endcase

      pressed_n = (state_n == DOWN) || (state_n == DB_RELEASE);
      press_n   = (state == DB_PRESS) && (state_n == DOWN);
      release_n = (state == DB_RELEASE) && (state_n == IDLE);
      // Repeat only while still held; a release in the same cycle wins
      repeat_n  = ((state == DOWN) || (state == DB_RELEASE)) &&
                  (state_n != IDLE) && (hcnt_n == HOLD_TGT);
    end

    assign Pressed[i]    = pressed_q;
    assign KeyPress[i]   = press_q;
    assign KeyRelease[i] = release_q;
    assign KeyRepeat[i]  = repeat_q;
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner with small debounce/hold/repeat counts.
module tb_key_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key;
  logic [3:0] pressed, key_press, key_release, key_repeat;

  key_conditioner #(
    .N_KEYS(4), .DB_CYCLES(4), .HOLD_CYCLES(10), .RPT_CYCLES(3)
  ) dut (
    .CLOCK_50  (clk),
    .Reset     (rst),
    .KEY       (key),
    .Pressed   (pressed),
    .KeyPress  (key_press),
    .KeyRelease(key_release),
    .KeyRepeat (key_repeat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [3:0] pressed;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] rpt;
  } ev_t;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int at, input logic [3:0] p, input logic [3:0] kp,
                      input logic [3:0] kr, input logic [3:0] rp);
    ev_t e;
    e.at = at; e.pressed = p; e.press = kp; e.rel = kr; e.rpt = rp;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_to(input int target);
    while (cyc < target) tick();
  endtask

  // Monitor: any pulse or level change must match the next expected event
  initial begin
    logic [3:0] prev;
    ev_t        e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = '0;
      end else if ((key_press | key_release | key_repeat) != 4'b0 || pressed != prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event cycle=%0d pressed=%b press=%b release=%b repeat=%b",
                   cyc, pressed, key_press, key_release, key_repeat);
        end else begin
          e = exp_q.pop_front();
          check("event_cycle", cyc, e.at);
          check("pressed", int'(pressed), int'(e.pressed));
          check("key_press", int'(key_press), int'(e.press));
          check("key_release", int'(key_release), int'(e.rel));
          check("key_repeat", int'(key_repeat), int'(e.rpt));
        end
        prev = pressed;
      end
    end
  end

  initial begin
    int c;
    rst = 1'b1;
    key = 4'hF;
    repeat (3) tick();
    check("reset_pressed", int'(pressed), 0);
    check("reset_press", int'(key_press), 0);
    check("reset_release", int'(key_release), 0);
    check("reset_repeat", int'(key_repeat), 0);
    rst = 1'b0;

    // Key 0: accept, repeats, glitch while held, release
    tick();
    c = cyc;
    key[0] = 1'b0;
    push(c + 7, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    for (int k = 17; k <= 29; k += 3) push(c + k, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    push(c + 31, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    tick_to(c + 18); key[0] = 1'b1;
    tick_to(c + 20); key[0] = 1'b0;
    tick_to(c + 24); key[0] = 1'b1;
    tick_to(c + 40);

    // Key 1: short bounce must be rejected
    c = cyc;
    key[1] = 1'b0;
    tick_to(c + 3); key[1] = 1'b1;
    tick_to(c + 20);
    check("bounce_pressed1", int'(pressed[1]), 0);

    // Key 2: long hold, repeat cadence, repeat suppressed on release cycle
    c = cyc;
    key[2] = 1'b0;
    push(c + 7, 4'b0100, 4'b0100, 4'b0000, 4'b0000);
    for (int k = 17; k <= 41; k += 3) push(c + k, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
    push(c + 44, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
    tick_to(c + 37); key[2] = 1'b1;
    tick_to(c + 55);

    // Key 3: reset during hold, re-acceptance after reset release
    c = cyc;
    key[3] = 1'b0;
    push(c + 7, 4'b1000, 4'b1000, 4'b0000, 4'b0000);
    push(c + 18, 4'b1000, 4'b1000, 4'b0000, 4'b0000);
    push(c + 27, 4'b0000, 4'b0000, 4'b1000, 4'b0000);
    tick_to(c + 9);
    rst = 1'b1;
    #1;
    check("midreset_pressed", int'(pressed), 0);
    check("midreset_press", int'(key_press), 0);
    check("midreset_release", int'(key_release), 0);
    check("midreset_repeat", int'(key_repeat), 0);
    tick_to(c + 11);
    check("inreset_pressed", int'(pressed), 0);
    rst = 1'b0;
    tick_to(c + 20); key[3] = 1'b1;
    tick_to(c + 35);

    // All keys together
    c = cyc;
    key = 4'h0;
    push(c + 7, 4'hF, 4'hF, 4'h0, 4'h0);
    push(c + 16, 4'h0, 4'h0, 4'hF, 4'h0);
    tick_to(c + 9); key = 4'hF;
    tick_to(c + 30);

    while (exp_q.size() > 0) begin
      ev_t e;
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_event expected at cycle %0d, not seen", e.at);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
